mmio_store_port: RTL and testbench

Memory-mapped store-bus responder sitting beside data memory on the processor's `MemWrite`/`DataAdr`/`WriteData` bus. It captures word stores to a data address into a small FIFO and drains them to a downstream consumer (console, checker, host link) over a valid/ready handshake. It exposes a readable status word and a write-to-clear control word. The processor is single-cycle and cannot stall, so the block never back-pressures the store bus; it drops on overflow and flags it.

---
 rtl/mmio_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/mmio_store_port.sv | 73 +++++++
 tb/tb_mmio_store_port.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared address map, status-word layout and control bits for the MMIO store port.
package mmio_pkg;

    localparam logic [31:0] DATA_OFS   = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;
    localparam logic [31:0] CTRL_OFS   = 32'd8;

    localparam int OVF_BIT   = 31;
    localparam int EMPTY_BIT = 9;
    localparam int FULL_BIT  = 8;
    localparam int CNT_LSB   = 0;
    localparam int CNT_W     = 8;

    localparam int CLR_OVF_BIT = 0;

    function automatic logic [31:0] makeStatus(input logic ovf, input logic empty,
                                               input logic full, input logic [CNT_W-1:0] cnt);
        logic [31:0] word;
        word = '0;
        word[OVF_BIT] = ovf;
        word[EMPTY_BIT] = empty;
        word[FULL_BIT] = full;
        word[CNT_LSB +: CNT_W] = cnt;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO that never back-pressures: a push while full without a
// simultaneous pop is dropped and reported, leaving stored entries untouched.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         pushData,
    output logic [WIDTH-1:0]         headData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtrReg;
    logic [PTR_W-1:0] rdPtrReg;
    logic [PTR_W:0]   countReg;
    logic             doPop;
    logic             doPush;

    assign empty   = (countReg == '0);
    assign full    = (countReg == (PTR_W+1)'(DEPTH));
    assign count   = countReg;
    // A pop frees the slot in the same edge, so a full FIFO still accepts then.
    assign doPop   = pop & ~empty;
    assign doPush  = push & (~full | doPop);
    assign dropped = push & full & ~doPop;

    assign headData = empty ? '0 : mem[rdPtrReg];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (doPush) begin
            mem[wrPtrReg] <= pushData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + (PTR_W+1)'(1);
                2'b01:   countReg <= countReg - (PTR_W+1)'(1);
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_store_port.sv
// Store-bus responder: queues word stores to BASE_ADDR for a valid/ready consumer,
// with a sticky overflow flag, a readable status word and a write-to-clear control word.
module mmio_store_port
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'd128,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        OutValid,
    output logic [31:0] OutData,
    input  logic        OutReady,
    output logic        Overflow
);

    localparam logic [31:0] DATA_ADDR   = BASE_ADDR + DATA_OFS;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;
    localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFS;

    logic                   pushReq;
    logic                   clrReq;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   fifoDropped;
    logic [$clog2(DEPTH):0] fifoCount;
    logic                   overflowReg;

    assign pushReq = MemWrite & (DataAdr == DATA_ADDR);
    assign clrReq  = MemWrite & (DataAdr == CTRL_ADDR) & WriteData[CLR_OVF_BIT];

    sync_fifo #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (pushReq),
        .pop     (OutReady),
        .pushData(WriteData),
        .headData(OutData),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .count   (fifoCount),
        .dropped (fifoDropped)
    );

    assign OutValid = ~fifoEmpty;
    assign Overflow = overflowReg;

    // Setting takes priority so a drop is never hidden by a concurrent clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflowReg <= 1'b0;
        end else if (fifoDropped) begin
            overflowReg <= 1'b1;
        end else if (clrReq) begin
            overflowReg <= 1'b0;
        end
    end

    always_comb begin
        ReadData = '0;
        if (DataAdr == STATUS_ADDR) begin
            ReadData = makeStatus(overflowReg, fifoEmpty, fifoFull, CNT_W'(fifoCount));
        end
    end

endmodule

// File: tb/tb_mmio_store_port.sv
// Directed bench for mmio_store_port: push/pop ordering, overflow, control clear,
// address decode and asynchronous reset.
module tb_mmio_store_port;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        OutValid;
    logic [31:0] OutData;
    logic        OutReady;
    logic        Overflow;

    int errors = 0;
    int checks = 0;

    mmio_store_port dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .OutValid (OutValid),
        .OutData  (OutData),
        .OutReady (OutReady),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkStatus(input string tag, input logic [31:0] exp);
        MemWrite = 1'b0;
        DataAdr  = 32'd132;
        #1;
        chk(tag, ReadData, exp);
        DataAdr  = 32'd0;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;
        $display("store adr=%0d data=%h -> valid=%b head=%h ovf=%b", adr, data, OutValid, OutData, Overflow);
    endtask

    task automatic popOne(input string tag, input logic [31:0] exp);
        chk(tag, OutData, exp);
        OutReady = 1'b1;
        @(posedge clk);
        #1;
        OutReady = 1'b0;
        $display("pop expected=%h -> next valid=%b head=%h", exp, OutValid, OutData);
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;
        OutReady  = 1'b0;
        #12;
        chk("rst_valid", 32'(OutValid), 32'd0);
        chk("rst_data", OutData, 32'd0);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        chkStatus("rst_status", 32'h0000_0200);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single push, then single pop
        store(32'd128, 32'd254);
        chk("t1_valid", 32'(OutValid), 32'd1);
        chk("t1_data", OutData, 32'd254);
        chkStatus("t1_status", 32'h0000_0001);
        popOne("t1_pop", 32'd254);
        chk("t1_valid_after", 32'(OutValid), 32'd0);
        chkStatus("t1_status_after", 32'h0000_0200);

        // Fill and overflow
        for (int i = 1; i <= 4; i++) store(32'd128, 32'(i));
        chkStatus("t2_full_status", 32'h0000_0104);
        store(32'd128, 32'hDEAD);
        chk("t2_ovf", 32'(Overflow), 32'd1);
        chkStatus("t2_status", 32'h8000_0104);
        for (int i = 1; i <= 4; i++) popOne("t2_pop", 32'(i));
        chk("t2_empty", 32'(OutValid), 32'd0);
        chkStatus("t2_status_empty", 32'h8000_0200);

        // Control clear: bit0=0 leaves the flag, bit0=1 clears it
        store(32'd136, 32'd2);
        chk("t3_noclr", 32'(Overflow), 32'd1);
        store(32'd136, 32'd1);
        chk("t3_clr", 32'(Overflow), 32'd0);

        // Push into a full FIFO with a simultaneous pop
        for (int i = 1; i <= 4; i++) store(32'd128, 32'(i));
        OutReady = 1'b1;
        store(32'd128, 32'd5);
        OutReady = 1'b0;
        chk("t4_head", OutData, 32'd2);
        chk("t4_ovf", 32'(Overflow), 32'd0);
        chkStatus("t4_status", 32'h0000_0104);
        for (int i = 2; i <= 5; i++) popOne("t4_pop", 32'(i));
        chk("t4_empty", 32'(OutValid), 32'd0);

        // Drop, clear, drop again re-sets the flag
        for (int i = 1; i <= 4; i++) store(32'd128, 32'(i + 10));
        store(32'd128, 32'd9);
        chk("t5_ovf_set", 32'(Overflow), 32'd1);
        store(32'd136, 32'd1);
        chk("t5_ovf_clr", 32'(Overflow), 32'd0);
        store(32'd128, 32'd9);
        chk("t5_ovf_reset", 32'(Overflow), 32'd1);
        for (int i = 1; i <= 4; i++) popOne("t5_pop", 32'(i + 10));
        store(32'd136, 32'd1);
        chk("t5_ovf_final", 32'(Overflow), 32'd0);

        // Stores to other addresses are ignored
        store(32'd100, 32'd77);
        store(32'd132, 32'd78);
        store(32'd124, 32'd79);
        chk("t6_valid", 32'(OutValid), 32'd0);
        chk("t6_ovf", 32'(Overflow), 32'd0);
        chkStatus("t6_status", 32'h0000_0200);
        DataAdr = 32'd128;
        #1;
        chk("t6_rd_other", ReadData, 32'd0);
        DataAdr = 32'd0;

        // Asynchronous reset with three queued entries and the flag set
        for (int i = 1; i <= 4; i++) store(32'd128, 32'(i + 20));
        store(32'd128, 32'd99);
        popOne("t7_pop", 32'd21);
        chkStatus("t7_pre_status", 32'h8000_0003);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_rst_valid", 32'(OutValid), 32'd0);
        chk("t7_rst_data", OutData, 32'd0);
        chk("t7_rst_ovf", 32'(Overflow), 32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        store(32'd128, 32'd7);
        chk("t7_data", OutData, 32'd7);
        chkStatus("t7_status", 32'h0000_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
